// File: rtl/traffic_light_ped_ctrl.sv
// traffic_light_ped_ctrl
//   Two-way intersection controller with pedestrian walk service, early
//   green termination bounded by a minimum green, and a night flashing mode
//   that is entered and left only through an all-red interval.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   ped_ns_req  NS crosswalk button (level or pulse)
//   ped_ew_req  EW crosswalk button (level or pulse)
//   night       level, requests night flashing mode
//   ns, ew      vehicle heads, one-hot {red, yellow, green}
//   p_ns, p_ew  pedestrian heads, one-hot {dont_walk, flash_dont_walk, walk},
//               000 = dark
//   pend_ns/ew  walk request latched and not yet serviced
module traffic_light_ped_ctrl #(
  parameter int GREEN_T    = 20,
  parameter int MIN_GREEN  = 6,
  parameter int YELLOW_T   = 4,
  parameter int ALLRED_T   = 2,
  parameter int WALK_T     = 8,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_ns_req,
  input  logic       ped_ew_req,
  input  logic       night,
  output logic [2:0] ns,
  output logic [2:0] ew,
  output logic [2:0] p_ns,
  output logic [2:0] p_ew,
  output logic       pend_ns,
  output logic       pend_ew
);

  typedef enum logic [2:0] {
    S_NS_G, S_NS_Y, S_AR1, S_EW_G, S_EW_Y, S_AR2, S_FLASH
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] WALK_LEN    = CNT_W'(WALK_T);

  state_t           state_q;
  logic [CNT_W-1:0] timer_q;
  logic             pend_ns_q, pend_ew_q;
  logic             walk_ns_q, walk_ew_q;
  logic             blink_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_AR2;
      timer_q   <= '0;
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      timer_q <= timer_q + 1'b1;

      // Requests latch every edge except while flashing; the case below
      // overrides these on green entry and on FLASH entry.
      if (state_q == S_FLASH) begin
        pend_ns_q <= 1'b0;
        pend_ew_q <= 1'b0;
      end else begin
        pend_ns_q <= pend_ns_q | ped_ns_req;
        pend_ew_q <= pend_ew_q | ped_ew_req;
      end

      case (state_q)
        S_NS_G: begin
          // Early cut as soon as the cross street wants service (or night
          // is requested) and the minimum green has elapsed.
          if (timer_q == GREEN_LAST ||
              ((pend_ew_q | night) && timer_q >= MIN_LAST)) begin
            state_q   <= S_NS_Y;
            timer_q   <= '0;
            walk_ns_q <= 1'b0;
          end
        end
        S_NS_Y: begin
          if (timer_q == YELLOW_LAST) begin
            state_q <= S_AR1;
            timer_q <= '0;
          end
        end
        S_AR1: begin
          if (timer_q == ALLRED_LAST) begin
            timer_q <= '0;
            if (night) begin
              state_q   <= S_FLASH;
              blink_q   <= 1'b1;
              pend_ns_q <= 1'b0;
              pend_ew_q <= 1'b0;
            end else begin
              // A press on this very edge is serviced by this green.
              state_q   <= S_EW_G;
              walk_ew_q <= pend_ew_q | ped_ew_req;
              pend_ew_q <= 1'b0;
            end
          end
        end
        S_EW_G: begin
          if (timer_q == GREEN_LAST ||
              ((pend_ns_q | night) && timer_q >= MIN_LAST)) begin
            state_q   <= S_EW_Y;
            timer_q   <= '0;
            walk_ew_q <= 1'b0;
          end
        end
        S_EW_Y: begin
          if (timer_q == YELLOW_LAST) begin
            state_q <= S_AR2;
            timer_q <= '0;
          end
        end
        S_AR2: begin
          if (timer_q == ALLRED_LAST) begin
            timer_q <= '0;
            if (night) begin
              state_q   <= S_FLASH;
              blink_q   <= 1'b1;
              pend_ns_q <= 1'b0;
              pend_ew_q <= 1'b0;
            end else begin
              state_q   <= S_NS_G;
              walk_ns_q <= pend_ns_q | ped_ns_req;
              pend_ns_q <= 1'b0;
            end
          end
        end
        S_FLASH: begin
          if (!night) begin
            state_q <= S_AR2;
            timer_q <= '0;
          end else if (timer_q == FLASH_LAST) begin
            timer_q <= '0;
            blink_q <= ~blink_q;
          end
        end
        default: begin
          state_q <= S_AR2;
          timer_q <= '0;
        end
      endcase
    end
  end

  // Moore decode of the registered state.
  always_comb begin
    ns   = 3'b100;
    ew   = 3'b100;
    p_ns = 3'b100;
    p_ew = 3'b100;
    case (state_q)
      S_NS_G: begin
        ns = 3'b001;
        if (walk_ns_q) p_ns = (timer_q < WALK_LEN) ? 3'b001 : 3'b010;
      end
      S_NS_Y: ns = 3'b010;
      S_EW_G: begin
        ew = 3'b001;
        if (walk_ew_q) p_ew = (timer_q < WALK_LEN) ? 3'b001 : 3'b010;
      end
      S_EW_Y: ew = 3'b010;
      S_FLASH: begin
        ns   = blink_q ? 3'b010 : 3'b000;
        ew   = blink_q ? 3'b100 : 3'b000;
        p_ns = 3'b000;
        p_ew = 3'b000;
      end
      default: ;
    endcase
  end

  assign pend_ns = pend_ns_q;
  assign pend_ew = pend_ew_q;

endmodule

// File: tb/tb_traffic_light_ped_ctrl.sv
// Directed bench for traffic_light_ped_ctrl with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_light_ped_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_ns_req = 1'b0;
  logic       ped_ew_req = 1'b0;
  logic       night = 1'b0;
  logic [2:0] ns, ew, p_ns, p_ew;
  logic       pend_ns, pend_ew;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_light_ped_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ped_ns_req (ped_ns_req),
    .ped_ew_req (ped_ew_req),
    .night      (night),
    .ns         (ns),
    .ew         (ew),
    .p_ns       (p_ns),
    .p_ew       (p_ew),
    .pend_ns    (pend_ns),
    .pend_ew    (pend_ew)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic heads(input string tag, input logic [2:0] e_ns, input logic [2:0] e_ew,
                       input logic [2:0] e_pns, input logic [2:0] e_pew);
    chk({tag, ".ns"},   ns,   e_ns);
    chk({tag, ".ew"},   ew,   e_ew);
    chk({tag, ".p_ns"}, p_ns, e_pns);
    chk({tag, ".p_ew"}, p_ew, e_pew);
  endtask

  task automatic pends(input string tag, input logic e_ns, input logic e_ew);
    chk({tag, ".pend_ns"}, {2'b00, pend_ns}, {2'b00, e_ns});
    chk({tag, ".pend_ew"}, {2'b00, pend_ew}, {2'b00, e_ew});
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    // Reset state: AR2, timer 0.
    heads("reset", 3'b100, 3'b100, 3'b100, 3'b100);
    pends("reset", 1'b0, 1'b0);

    // ---- Free-running cycle, no inputs ----
    step(1);  heads("ar2_t1",   3'b100, 3'b100, 3'b100, 3'b100);
    step(1);  heads("nsg_t0",   3'b001, 3'b100, 3'b100, 3'b100);
    step(19); heads("nsg_t19",  3'b001, 3'b100, 3'b100, 3'b100);
    step(1);  heads("nsy_t0",   3'b010, 3'b100, 3'b100, 3'b100);
    step(3);  heads("nsy_t3",   3'b010, 3'b100, 3'b100, 3'b100);
    step(1);  heads("ar1_t0",   3'b100, 3'b100, 3'b100, 3'b100);
    step(1);  heads("ar1_t1",   3'b100, 3'b100, 3'b100, 3'b100);
    step(1);  heads("ewg_t0",   3'b100, 3'b001, 3'b100, 3'b100);
    step(19); heads("ewg_t19",  3'b100, 3'b001, 3'b100, 3'b100);
    step(1);  heads("ewy_t0",   3'b100, 3'b010, 3'b100, 3'b100);
    step(4);  heads("ar2b_t0",  3'b100, 3'b100, 3'b100, 3'b100);
    step(2);  heads("nsg2_t0",  3'b001, 3'b100, 3'b100, 3'b100);

    // ---- NS request during EW_G cuts EW_G at 6 cycles ----
    step(28);                                  // EW_G t2
    heads("ewg_pre", 3'b100, 3'b001, 3'b100, 3'b100);
    ped_ns_req = 1'b1;
    step(1);                                   // EW_G t3
    ped_ns_req = 1'b0;
    pends("nsreq_latched", 1'b1, 1'b0);
    step(2);  heads("ewg_cut_t5", 3'b100, 3'b001, 3'b100, 3'b100);
    step(1);  heads("ewy_cut_t0", 3'b100, 3'b010, 3'b100, 3'b100);
    pends("nsreq_held", 1'b1, 1'b0);
    step(6);                                   // NS_G t0 with walk
    heads("nswalk_t0", 3'b001, 3'b100, 3'b001, 3'b100);
    pends("nswalk_cleared", 1'b0, 1'b0);
    step(7);  heads("nswalk_t7",  3'b001, 3'b100, 3'b001, 3'b100);
    step(1);  heads("nsflash_t8", 3'b001, 3'b100, 3'b010, 3'b100);
    step(11); heads("nsflash_t19",3'b001, 3'b100, 3'b010, 3'b100);
    step(1);  heads("nsy_after_walk", 3'b010, 3'b100, 3'b100, 3'b100);

    // ---- EW request at NS_G timer 10 -> green lasts 12 ----
    step(6);  heads("ewg_nowalk", 3'b100, 3'b001, 3'b100, 3'b100);
    step(26); heads("nsg_nowalk", 3'b001, 3'b100, 3'b100, 3'b100);
    step(10);                                  // NS_G t10
    ped_ew_req = 1'b1;
    step(1);                                   // NS_G t11
    ped_ew_req = 1'b0;
    heads("nsg_t11", 3'b001, 3'b100, 3'b100, 3'b100);
    pends("ewreq_latched", 1'b0, 1'b1);
    step(1);  heads("nsy_cut12", 3'b010, 3'b100, 3'b100, 3'b100);
    step(6);  heads("ewwalk_t0", 3'b100, 3'b001, 3'b100, 3'b001);
    pends("ewwalk_cleared", 1'b0, 1'b0);
    step(7);  heads("ewwalk_t7",  3'b100, 3'b001, 3'b100, 3'b001);
    step(1);  heads("ewflash_t8", 3'b100, 3'b001, 3'b100, 3'b010);
    step(12); heads("ewy_after_walk", 3'b100, 3'b010, 3'b100, 3'b100);

    // ---- NS walk granted on entry edge, EW request at NS_G timer 1 ----
    step(5);                                   // AR2 t1
    ped_ns_req = 1'b1;
    step(1);                                   // NS_G t0, request on entry edge
    ped_ns_req = 1'b0;
    heads("entry_walk_t0", 3'b001, 3'b100, 3'b001, 3'b100);
    pends("entry_serviced", 1'b0, 1'b0);
    step(1);                                   // NS_G t1
    ped_ew_req = 1'b1;
    step(1);                                   // NS_G t2
    ped_ew_req = 1'b0;
    pends("early_ewreq", 1'b0, 1'b1);
    step(3);  heads("min_green_t5", 3'b001, 3'b100, 3'b001, 3'b100);
    step(1);  heads("min_green_y",  3'b010, 3'b100, 3'b100, 3'b100);
    step(6);  heads("ewwalk2_t0",   3'b100, 3'b001, 3'b100, 3'b001);

    // ---- Night mode entered mid NS_G ----
    step(26); heads("nsg_night_t0", 3'b001, 3'b100, 3'b100, 3'b100);
    step(2);                                   // NS_G t2
    night = 1'b1;
    step(3);  heads("night_g_t5", 3'b001, 3'b100, 3'b100, 3'b100);
    step(1);  heads("night_y_t0", 3'b010, 3'b100, 3'b100, 3'b100);
    step(4);  heads("night_ar1",  3'b100, 3'b100, 3'b100, 3'b100);
    step(2);  heads("flash_lit0", 3'b010, 3'b100, 3'b000, 3'b000);
    ped_ns_req = 1'b1;
    ped_ew_req = 1'b1;
    step(3);  heads("flash_lit3", 3'b010, 3'b100, 3'b000, 3'b000);
    pends("flash_ignore", 1'b0, 1'b0);
    step(1);  heads("flash_dark0", 3'b000, 3'b000, 3'b000, 3'b000);
    ped_ns_req = 1'b0;
    ped_ew_req = 1'b0;
    step(3);  heads("flash_dark3", 3'b000, 3'b000, 3'b000, 3'b000);
    step(1);  heads("flash_lit_again", 3'b010, 3'b100, 3'b000, 3'b000);
    night = 1'b0;
    step(1);  heads("night_exit_ar2", 3'b100, 3'b100, 3'b100, 3'b100);
    pends("night_exit", 1'b0, 1'b0);
    step(1);  heads("night_exit_ar2_t1", 3'b100, 3'b100, 3'b100, 3'b100);
    step(1);  heads("night_exit_nsg", 3'b001, 3'b100, 3'b100, 3'b100);

    // ---- Reset during EW_Y with a pending NS request ----
    step(26);                                  // EW_G t0
    ped_ns_req = 1'b1;
    step(1);                                   // EW_G t1
    ped_ns_req = 1'b0;
    step(5);  heads("pre_rst_ewy", 3'b100, 3'b010, 3'b100, 3'b100);
    pends("pre_rst", 1'b1, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    heads("mid_rst", 3'b100, 3'b100, 3'b100, 3'b100);
    pends("mid_rst", 1'b0, 1'b0);
    step(1);  heads("post_rst_ar2_t1", 3'b100, 3'b100, 3'b100, 3'b100);
    step(1);  heads("post_rst_nsg", 3'b001, 3'b100, 3'b100, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
